// File: rtl/quad_pkg.sv
// Shared encodings and helpers for the quadrature step decoder.
// Phase values are {A,B}; forward order is 00->01->11->10.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILL
  } step_e;

  function automatic logic [1:0] next_fwd(input logic [1:0] ph);
    logic [1:0] nx;
    nx = PH_00;
    unique case (ph)
      PH_00: nx = PH_01;
      PH_01: nx = PH_11;
      PH_11: nx = PH_10;
      PH_10: nx = PH_00;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// Per-channel synchronizer followed by a persistence glitch filter.
// A new level is accepted only after DEBOUNCE_CYC consecutive mismatches.
module quad_chan_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // Acceptance happens on the edge where the count would reach the limit.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (synced != filt_q) begin
      if (cnt_q == LIMIT) filt_d = synced;
      else                cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front-end: filtered A/B to count strobe, direction and
// illegal-transition reporting with a saturating error counter.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 3,
  parameter int ERR_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             dir_inv,
  input  logic             clr_err,
  output logic             en,
  output logic             ud,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       phase
);

  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

  logic             a_f, b_f;
  logic [1:0]       ab;
  step_e            step;
  logic [1:0]       phase_q, phase_d;
  logic             en_q, en_d;
  logic             ud_q, ud_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  quad_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_filt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (a_in),
    .filt_o(a_f)
  );

  quad_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_filt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (b_in),
    .filt_o(b_f)
  );

  assign ab = {a_f, b_f};

  always_comb begin
    step = STEP_NONE;
    unique case (1'b1)
      (ab == phase_q):           step = STEP_NONE;
      (ab == next_fwd(phase_q)): step = STEP_FWD;
      (next_fwd(ab) == phase_q): step = STEP_REV;
      default:                   step = STEP_ILL;
    endcase
  end

  // Phase follows the filtered inputs even on illegal steps to resync.
  always_comb begin
    phase_d = ab;
    en_d    = (step == STEP_FWD) || (step == STEP_REV);
    err_d   = (step == STEP_ILL);
    ud_d    = ud_q;
    if (en_d)
      ud_d = ((step == STEP_FWD) ? DIR_UP : DIR_DN) ^ dir_inv;
    cnt_d = clr_err ? '0 : cnt_q;
    if (err_d && (cnt_d != CNT_MAX))
      cnt_d = cnt_d + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_00;
      en_q    <= 1'b0;
      ud_q    <= DIR_UP;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      en_q    <= en_d;
      ud_q    <= ud_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign en      = en_q;
  assign ud      = ud_q;
  assign err     = err_q;
  assign err_cnt = cnt_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: directed steps queue expected
// pulses; a negedge monitor pops and compares every en/err pulse.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       dir_inv = 1'b0;
  logic       clr_err = 1'b0;
  logic       en, ud, err;
  logic [3:0] err_cnt;
  logic [1:0] phase;

  quad_step_decoder #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(3),
    .ERR_W       (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_in   (a_in),
    .b_in   (b_in),
    .dir_inv(dir_inv),
    .clr_err(clr_err),
    .en     (en),
    .ud     (ud),
    .err    (err),
    .err_cnt(err_cnt),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    bit         ud;
    logic [1:0] ph;
    logic [3:0] cnt;
    int         at;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic void expect_ev(bit is_err, bit u, logic [1:0] p,
                                    logic [3:0] c, int at);
    exp_t e;
    e.is_err = is_err;
    e.ud     = u;
    e.ph     = p;
    e.cnt    = c;
    e.at     = at;
    q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, input bit is_err,
                       input bit u, input logic [1:0] p,
                       input logic [3:0] c, input int hold);
    a_in = a;
    b_in = b;
    expect_ev(is_err, u, p, c, cyc + 6);
    tick(hold);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (en || err)) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d en=%b err=%b ud=%b ph=%b cnt=%0d",
                 cyc, en, err, ud, phase, err_cnt);
      end else begin
        e = q.pop_front();
        if (en !== !e.is_err || err !== e.is_err || ud !== e.ud ||
            phase !== e.ph || err_cnt !== e.cnt || cyc != e.at) begin
          failures++;
          $display("FAIL pulse actual: cyc=%0d en=%b err=%b ud=%b ph=%b cnt=%0d expected: cyc=%0d err=%b ud=%b ph=%b cnt=%0d",
                   cyc, en, err, ud, phase, err_cnt,
                   e.at, e.is_err, e.ud, e.ph, e.cnt);
        end
      end
    end
  end

  initial begin
    int c;
    logic s;
    tick(2);
    chk("rst_en", en, 0);
    chk("rst_ud", ud, 1);
    chk("rst_err", err, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_phase", phase, 0);
    rst_n = 1'b1;
    tick(3);

    // forward, ud=1
    drive(0, 1, 0, 1, 2'b01, 0, 20);
    drive(1, 1, 0, 1, 2'b11, 0, 20);
    drive(1, 0, 0, 1, 2'b10, 0, 20);
    drive(0, 0, 0, 1, 2'b00, 0, 20);
    // reverse, dir_inv=0 -> ud=0
    drive(1, 0, 0, 0, 2'b10, 0, 20);
    drive(1, 1, 0, 0, 2'b11, 0, 20);
    drive(0, 1, 0, 0, 2'b01, 0, 20);
    drive(0, 0, 0, 0, 2'b00, 0, 20);
    // reverse, dir_inv=1 -> ud=1
    dir_inv = 1'b1;
    drive(1, 0, 0, 1, 2'b10, 0, 20);
    drive(1, 1, 0, 1, 2'b11, 0, 20);
    drive(0, 1, 0, 1, 2'b01, 0, 20);
    drive(0, 0, 0, 1, 2'b00, 0, 20);
    dir_inv = 1'b0;

    // 2-cycle glitch on A is discarded
    a_in = 1'b1;
    tick(2);
    a_in = 1'b0;
    tick(20);
    chk("glitch_phase", phase, 0);
    chk("glitch_cnt", err_cnt, 0);

    // 3-cycle pulse on B: accepted rise then accepted fall
    b_in = 1'b1;
    expect_ev(0, 1, 2'b01, 0, cyc + 6);
    expect_ev(0, 0, 2'b00, 0, cyc + 9);
    tick(3);
    b_in = 1'b0;
    tick(20);

    // illegal 00->11: ud held at 0, then legal steps resume
    drive(1, 1, 1, 0, 2'b11, 1, 20);
    drive(1, 0, 0, 1, 2'b10, 1, 20);
    drive(0, 0, 0, 1, 2'b00, 1, 20);

    // 17 illegal jumps saturate the counter at 15
    for (int i = 1; i <= 17; i++) begin
      s = i[0];
      c = (1 + i > 15) ? 15 : 1 + i;
      drive(s, s, 1, 1, {s, s}, 4'(c), 12);
    end
    chk("sat_cnt", err_cnt, 15);

    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_cnt", err_cnt, 0);
    tick(2);

    drive(0, 0, 1, 1, 2'b00, 1, 20);

    // clear coinciding with an illegal step leaves count at 1
    a_in = 1'b1;
    b_in = 1'b1;
    expect_ev(1, 1, 2'b11, 1, cyc + 6);
    tick(5);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(14);

    // back-to-back forward steps 11->10->00
    b_in = 1'b0;
    expect_ev(0, 1, 2'b10, 1, cyc + 6);
    tick(1);
    a_in = 1'b0;
    expect_ev(0, 1, 2'b00, 1, cyc + 6);
    tick(20);

    // async reset in the middle of a pending step
    drive(1, 0, 0, 0, 2'b10, 1, 20);
    a_in = 1'b1;
    b_in = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", en, 0);
    chk("mid_rst_ud", ud, 1);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    chk("mid_rst_phase", phase, 0);
    q.delete();
    a_in = 1'b0;
    b_in = 1'b0;
    tick(3);
    #3 rst_n = 1'b1;
    tick(2);
    drive(0, 1, 0, 1, 2'b01, 0, 20);

    chk("pending_left", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
